// File: rtl/fifo_defs.vh
// Default geometry and threshold settings shared by the FIFO modules.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEF_B              8
`define FIFO_DEF_W              4
`define FIFO_DEF_AF_LVL(w)      ((2**(w)) - 2)
`define FIFO_DEF_AE_LVL         2

`endif

// File: rtl/fifo_mem.sv
// FIFO storage: B x 2**W words, synchronous write port, asynchronous read port.
`include "fifo_defs.vh"

module fifo_mem #(
    parameter int B = `FIFO_DEF_B,
    parameter int W = `FIFO_DEF_W
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [W-1:0] r_addr,
    output logic [B-1:0] r_data
);

    localparam int DEPTH = 2 ** W;

    // No reset on the array so it maps onto distributed RAM.
    logic [B-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_lvl.sv
// First-word-fall-through FIFO with registered occupancy level, threshold
// flags and sticky overflow/underflow error flags.
`include "fifo_defs.vh"

module fifo_lvl #(
    parameter int B      = `FIFO_DEF_B,
    parameter int W      = `FIFO_DEF_W,
    parameter int AF_LVL = `FIFO_DEF_AF_LVL(W),
    parameter int AE_LVL = `FIFO_DEF_AE_LVL
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    input  logic         flush,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   level,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH_L = (W + 1)'(2 ** W);
    localparam logic [W:0] AF_THR  = (W + 1)'(AF_LVL);
    localparam logic [W:0] AE_THR  = (W + 1)'(AE_LVL);

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   level_q, level_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ae_q, ae_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         wr_acc, rd_acc;

    always_comb begin
        wr_acc   = wr & ~full_q & ~flush;
        rd_acc   = rd & ~empty_q & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A fresh error event outranks clr_err; flush masks the request entirely.
        ovf_d = (ovf_q & ~clr_err) | (wr & full_q & ~flush);
        udf_d = (udf_q & ~clr_err) | (rd & empty_q & ~flush);

        // Flags are registered from the next level so they never glitch.
        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH_L);
        ae_d    = (level_d <= AE_THR);
        af_d    = (level_d >= AF_THR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .B (B),
        .W (W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .w_addr (wr_ptr_q),
        .w_data (w_data),
        .r_addr (rd_ptr_q),
        .r_data (r_data)
    );

    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed and randomized checks of fifo_lvl against a queue-based model.
`timescale 1ns/1ps

module tb_fifo_lvl;

    localparam int B     = 8;
    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr, rd, flush, clr_err;
    logic [B-1:0] w_data;
    logic [B-1:0] r_data;
    logic         empty, full, almost_empty, almost_full;
    logic [W:0]   level;
    logic         overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents in arrival order plus the two sticky flags.
    byte unsigned m_q[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_lvl #(
        .B      (B),
        .W      (W),
        .AF_LVL (AF),
        .AE_LVL (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .w_data       (w_data),
        .flush        (flush),
        .clr_err      (clr_err),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int sz;
        sz = m_q.size();
        check_eq({ctx, ".level"},        32'(level),        32'(sz));
        check_eq({ctx, ".empty"},        32'(empty),        32'(sz == 0));
        check_eq({ctx, ".full"},         32'(full),         32'(sz == DEPTH));
        check_eq({ctx, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        check_eq({ctx, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        check_eq({ctx, ".overflow"},     32'(overflow),     32'(m_ovf));
        check_eq({ctx, ".underflow"},    32'(underflow),    32'(m_udf));
        if (sz > 0) check_eq({ctx, ".r_data"}, 32'(r_data), 32'(m_q[0]));
    endtask

    // One clock: drive inputs, advance model by the FIFO rules, compare after the edge.
    task automatic cycle(input string ctx, input bit w, input bit r, input bit f,
                         input bit c, input logic [7:0] d);
        int sz;
        bit wa, ra;
        wr      = w;
        rd      = r;
        flush   = f;
        clr_err = c;
        w_data  = d;
        sz = m_q.size();
        wa = w && (sz < DEPTH) && !f;
        ra = r && (sz > 0) && !f;
        @(posedge clk);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && sz == DEPTH && !f) m_ovf = 1'b1;
        if (r && sz == 0 && !f)     m_udf = 1'b1;
        if (f) begin
            m_q.delete();
        end else begin
            if (ra) void'(m_q.pop_front());
            if (wa) m_q.push_back(d);
        end
        #1;
        $display("[TB] %s wr=%0b rd=%0b flush=%0b clr=%0b din=%02h -> level=%0d r_data=%02h ovf=%0b udf=%0b",
                 ctx, w, r, f, c, d, level, r_data, overflow, underflow);
        check_all(ctx);
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        reset_n = 1'b0;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 1'b0, vals[i]);

        cycle("ovf_write", 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        cycle("clr_err",   1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        cycle("rw_empty", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle("to_lvl2",  1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 10; i++)
            cycle("rw_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));

        cycle("to_lvl3", 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
        cycle("flush",   1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);

        for (int i = 0; i < 3; i++) cycle("burst", 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h90 + i));
        wr = 1'b1;
        w_data = 8'h99;
        #1 reset_n = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_all("async_rst");
        wr = 1'b0;
        #1 reset_n = 1'b1;
        cycle("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);

        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 15) == 0),
                  8'($urandom));
        end

        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
FIFO_LVL -- requirements
Module: fifo_lvl

Interface
REQ-001 Parameter B, default 8, data word width in bits.
REQ-002 Parameter W, default 4, address width; depth DEPTH = 2**W words.
REQ-003 Parameter AF_LVL, default 2**W-2, almost-full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LVL, default 2, almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read request; pops head word.
REQ-009 w_data  input  B  write data.
REQ-010 flush  input  1  synchronous clear of contents.
REQ-011 clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 r_data  output  B  head word, first-word-fall-through.
REQ-013 empty, full  output  1 each  occupancy flags.
REQ-014 almost_empty, almost_full  output  1 each  threshold flags.
REQ-015 level  output  W+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted (wr_acc) SHALL be wr & ~full & ~flush; accepted word stored at write pointer, pointer +1 mod DEPTH.
REQ-018 Read accepted (rd_acc) SHALL be rd & ~empty & ~flush; read pointer +1 mod DEPTH.
REQ-019 r_data SHALL present word at read pointer combinationally, zero latency; content is don't-care while empty.
REQ-020 Word written in cycle N SHALL appear on r_data and clear empty after edge N (visible cycle N+1).
REQ-021 level SHALL be registered: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-022 rd & wr while empty: write only accepted, read ignored, underflow set.
REQ-023 rd & wr while full: read only accepted, write dropped, overflow set.
REQ-024 rd & wr, neither empty nor full: both accepted, level unchanged.
REQ-025 empty = (level==0); full = (level==DEPTH); both derived from registered state, glitch-free.
REQ-026 almost_full = (level >= AF_LVL); almost_empty = (level <= AE_LVL).
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication.
REQ-028 overflow SHALL set on wr & full; underflow on rd & empty; both hold until clr_err or reset.
REQ-029 clr_err SHALL clear flags; a new error event in the same cycle SHALL win (flag stays 1).
REQ-030 flush SHALL zero both pointers and level next edge, override wr/rd that cycle, not touch error flags, and set no error flag itself.

Reset
REQ-031 reset_n low SHALL immediately force: pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
REQ-032 Storage array SHALL NOT be reset; r_data undefined after reset.
REQ-033 Reset asserted mid-operation SHALL discard all contents; first edge after deassertion behaves as from empty.

Structure
REQ-034 Default B/W and threshold defaults SHALL live in shared header fifo_defs.vh; no other shared constants.
REQ-035 Storage SHALL be sub-module fifo_mem (B x DEPTH, one sync write port, one async read port); control/flags in fifo_lvl.
REQ-036 RTL SHALL be synthesizable with no latches; array inferable as distributed RAM.

Verification (B=8, W=2, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-037 Reset, write 0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_empty drops at level 2; almost_full at 3; full at 4; reads return 0x11..0x44 in order, empty at end.
REQ-038 Full, wr=1 w_data=0x55 -> dropped, overflow=1, level 4; clr_err -> overflow=0; subsequent reads never show 0x55.
REQ-039 Empty, rd=1 wr=1 w_data=0xA5 -> level 1, underflow=1, r_data=0xA5 next cycle.
REQ-040 Level 2, 10 cycles rd=wr=1 with incrementing data -> level stays 2, pointer wrap exercised, output order exact.
REQ-041 Level 3, flush with wr=1 -> level 0, empty=1, write discarded, error flags unchanged.
REQ-042 reset_n low asynchronously mid-burst at level 3 -> flags take reset values before next clk edge; after release, write 0x7E -> r_data 0x7E, level 1.
